// File: rtl/fsm_eg_param.sv
// fsm_eg_param: four-state Moore FSM with a parameterised S3 dwell counter,
// an S0->S1 transition counter and an optional S1 watchdog.
//
// Optional feature: define FSM_EG_TIMEOUT_EN to build the S1 watchdog. Without
// it, timeout is tied low and S1 may be held indefinitely.
//
// Parameters:
//   DATA_W   - width of x and y (2..32)
//   HOLD_CNT - dwell cycles in S3 (1..2^DATA_W-1)
//   TIMEOUT  - S1 watchdog limit in cycles (2..65535), used only with the watchdog
//
// Ports:
//   clk      in   clock, all state changes on the rising edge
//   rst_n    in   asynchronous active-low reset
//   a, b     in   control inputs
//   x        out  DATA_W  count of S0->S1 transitions (wraps)
//   y        out  DATA_W  Moore output decoded from registered state only
//   state_o  out  2       current state code (S0=0, S1=1, S2=2, S3=3)
//   done     out  1       one-cycle pulse in the first cycle back in S0 after S3
//   timeout  out  1       sticky watchdog flag, cleared only by reset

module fsm_eg_param #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned HOLD_CNT = 4,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a,
    input  logic              b,
    output logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] y,
    output logic [1:0]        state_o,
    output logic              done,
    output logic              timeout
);

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_e;

    localparam logic [DATA_W-1:0] HoldInit = DATA_W'(HOLD_CNT - 1);

    state_e            r_state;
    state_e            w_state_next;
    logic [DATA_W-1:0] r_x;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] w_hold_next;
    logic              r_done;
    logic              w_s0_to_s1;
    logic              w_s3_to_s0;

`ifdef FSM_EG_TIMEOUT_EN
    logic [15:0] r_wd;
    logic        r_timeout;
    logic        w_wd_expire;

    // Last permitted S1 cycle: the coming edge forces S0 whatever a/b say.
    assign w_wd_expire = (r_state == S1) && (r_wd == 16'(TIMEOUT - 1));
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S0;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and hold-counter logic
    always_comb begin
        w_state_next = S0;
        w_hold_next  = r_hold;
        case (r_state)
            S0: begin
                if (a && !b) begin
                    w_state_next = S1;
                end else if (a && b) begin
                    w_state_next = S2;
                end else begin
                    w_state_next = S0;
                end
            end
            S1: begin
                if (a) begin
                    w_state_next = S0;
                end else if (b) begin
                    w_state_next = S2;
                end else begin
                    w_state_next = S1;
                end
            end
            S2: begin
                w_state_next = S3;
                w_hold_next  = HoldInit;
            end
            S3: begin
                // b reloads the dwell and wins over an expired counter.
                if (b) begin
                    w_state_next = S3;
                    w_hold_next  = HoldInit;
                end else if (r_hold == '0) begin
                    w_state_next = S0;
                end else begin
                    w_state_next = S3;
                    w_hold_next  = r_hold - DATA_W'(1);
                end
            end
            default: w_state_next = S0;
        endcase
`ifdef FSM_EG_TIMEOUT_EN
        if (w_wd_expire) begin
            w_state_next = S0;
        end
`endif
    end

    // Outputs decoded from registers only
    always_comb begin
        y = '0;
        case (r_state)
            S0:      y = '0;
            S1:      y = '1;
            S2:      y = DATA_W'(1);
            S3:      y = r_hold;
            default: y = '0;
        endcase
    end

    assign state_o = r_state;
    assign x       = r_x;
    assign done    = r_done;

    assign w_s0_to_s1 = (r_state == S0) && (w_state_next == S1);
    assign w_s3_to_s0 = (r_state == S3) && (w_state_next == S0);

    // Transition counter, dwell counter and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_hold <= '0;
            r_done <= 1'b0;
        end else begin
            if (w_s0_to_s1) begin
                r_x <= r_x + DATA_W'(1);
            end
            r_hold <= w_hold_next;
            r_done <= w_s3_to_s0;
        end
    end

`ifdef FSM_EG_TIMEOUT_EN
    // Watchdog counts consecutive S1 cycles and clears on any exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd      <= '0;
            r_timeout <= 1'b0;
        end else begin
            if ((r_state == S1) && (w_state_next == S1)) begin
                r_wd <= r_wd + 16'd1;
            end else begin
                r_wd <= '0;
            end
            if (w_wd_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

endmodule
